coin_acceptor: RTL

COIN_ACCEPTOR -- requirements
Module: coin_acceptor

---
 rtl/coin_acceptor_pkg.sv | 24 ++
 rtl/coin_acceptor_if.sv | 12 +
 rtl/coin_acceptor_debounce.sv | 81 ++++++++
 rtl/coin_acceptor.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/coin_acceptor_pkg.sv
// Shared coin codes and debounce state encoding for the coin acceptor and the vending FSM.
package coin_acceptor_pkg;

    typedef logic [1:0] coin_t;

    localparam coin_t COIN_NONE = 2'b00;
    localparam coin_t COIN_05   = 2'b01;
    localparam coin_t COIN_10   = 2'b10;

    localparam int DEB_CNT_W = 8;
    localparam int JAM_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONFIRM = 2'd1,
        HELD    = 2'd2,
        RELEASE = 2'd3
    } deb_state_t;

    function automatic coin_t chan_code(input logic is_10);
        return is_10 ? COIN_10 : COIN_05;
    endfunction

endpackage

// File: rtl/coin_acceptor_if.sv
// Coin hand-off between the acceptor (master) and the vending FSM (slave).
interface coin_acceptor_if;
    import coin_acceptor_pkg::*;

    logic  coin_ready;
    coin_t coin;
    logic  reject;
    logic  jam;

    modport master (input coin_ready, output coin, output reject, output jam);
    modport slave  (output coin_ready, input coin, input reject, input jam);
endinterface

// File: rtl/coin_acceptor_debounce.sv
// Per-channel two-flop synchronizer and debounce FSM; emits one event per coin.
module coin_debounce
    import coin_acceptor_pkg::*;
#(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic s_o,
    output logic event_o
);

    localparam logic [DEB_CNT_W-1:0] DEB_LAST = DEB_CNT_W'(DEB_CYCLES);

    logic                 sync1_q;
    logic                 s_q;
    logic                 event_q;
    deb_state_t           state_q;
    logic [DEB_CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            s_q     <= 1'b0;
            event_q <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            s_q     <= sync1_q;
            event_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (s_q) begin
                        state_q <= CONFIRM;
                        cnt_q   <= DEB_CNT_W'(1);
                    end
                end
                CONFIRM: begin
                    if (!s_q) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q + DEB_CNT_W'(1) == DEB_LAST) begin
                        state_q <= HELD;
                        event_q <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + DEB_CNT_W'(1);
                    end
                end
                HELD: begin
                    if (!s_q) begin
                        state_q <= RELEASE;
                        cnt_q   <= DEB_CNT_W'(1);
                    end
                end
                RELEASE: begin
                    // A bounce back high resumes HELD, so the same coin never re-fires.
                    if (s_q) begin
                        state_q <= HELD;
                        cnt_q   <= '0;
                    end else if (cnt_q + DEB_CNT_W'(1) == DEB_LAST) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + DEB_CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign s_o     = s_q;
    assign event_o = event_q;

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor: two debounced sensors feeding a 2-entry FIFO towards the vending FSM.
// Optional jam detection is enabled with macro COIN_ACCEPTOR_JAM_DETECT_EN.
module coin_acceptor
    import coin_acceptor_pkg::*;
#(
    parameter int DEB_CYCLES = 4,
    parameter int JAM_CYCLES = 1000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           coin05_raw,
    input  logic           coin10_raw,
    coin_acceptor_if.master vend
);

    logic [1:0] raw_vec;
    logic [1:0] s_vec;
    logic [1:0] ev_vec;
    logic [1:0] ev_ok;
    logic       jam_w;

    // Channel 0 is the 0.5 sensor, channel 1 the 1.0 sensor.
    assign raw_vec = {coin10_raw, coin05_raw};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            coin_debounce #(
                .DEB_CYCLES(DEB_CYCLES)
            ) u_deb (
                .clk    (clk),
                .rst    (rst),
                .raw_i  (raw_vec[gi]),
                .s_o    (s_vec[gi]),
                .event_o(ev_vec[gi])
            );
        end
    endgenerate

`ifdef COIN_ACCEPTOR_JAM_DETECT_EN
    localparam logic [JAM_CNT_W-1:0] JAM_LAST = JAM_CNT_W'(JAM_CYCLES);
    localparam logic [DEB_CNT_W-1:0] DEB_LAST = DEB_CNT_W'(DEB_CYCLES);

    logic [1:0]           jam_hit;
    logic [DEB_CNT_W-1:0] low_cnt_q;
    logic                 jam_q;
    logic                 jam_d;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_jam
            logic [JAM_CNT_W-1:0] high_cnt_q;

            always_ff @(posedge clk) begin
                if (rst || !s_vec[gi]) begin
                    high_cnt_q <= '0;
                end else if (high_cnt_q != JAM_LAST) begin
                    high_cnt_q <= high_cnt_q + JAM_CNT_W'(1);
                end
            end

            assign jam_hit[gi] = s_vec[gi] && (high_cnt_q >= JAM_LAST - JAM_CNT_W'(1));
        end
    endgenerate

    always_comb begin
        jam_d = jam_q;
        if (|jam_hit) begin
            jam_d = 1'b1;
        end else if (jam_q && !(|s_vec) && (low_cnt_q >= DEB_LAST - DEB_CNT_W'(1))) begin
            jam_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            low_cnt_q <= '0;
            jam_q     <= 1'b0;
        end else begin
            jam_q <= jam_d;
            if (|s_vec) begin
                low_cnt_q <= '0;
            end else if (low_cnt_q != DEB_LAST) begin
                low_cnt_q <= low_cnt_q + DEB_CNT_W'(1);
            end
        end
    end

    assign jam_w = jam_q;
`else
    logic s_unused;
    assign s_unused = &s_vec;
    assign jam_w    = 1'b0;
`endif

    assign ev_ok = ev_vec & {2{~jam_w}};

    coin_t      fifo_q [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    coin_t      coin_q, coin_d;
    logic       reject_q, reject_d;
    coin_t      push_code;
    logic       pop, full, push, both, one;

    always_comb begin
        pop       = vend.coin_ready && (count_q != 2'd0);
        full      = (count_q == 2'd2);
        both      = &ev_ok;
        one       = ^ev_ok;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        push      = one && (!full || pop);
        reject_d  = both || (one && full && !pop);
        push_code = chan_code(ev_ok[1]);
        coin_d    = pop ? fifo_q[rd_ptr_q] : COIN_NONE;
        wr_ptr_d  = wr_ptr_q ^ push;
        rd_ptr_d  = rd_ptr_q ^ pop;
        count_d   = count_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            coin_q   <= COIN_NONE;
            reject_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            coin_q   <= coin_d;
            reject_q <= reject_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= push_code;
        end
    end

    assign vend.coin   = coin_q;
    assign vend.reject = reject_q;
    assign vend.jam    = jam_w;

endmodule
